hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller: sequences stalls, bubbles and flushes of the IF/ID and ID/EX
//  pipeline registers and the PC, and generates operand forwarding selects rfd1sel/rfd2sel.
//  Sits beside the decode stage; all enable/clear outputs drive the stage registers directly.
// PARAMETERS
//  REG_W     5   register-specifier width
//  MAX_WAIT  15  memory-wait cycles tolerated before wait_err is raised
//  CNT_W     16  width of stall_cnt (perf counter, optional feature)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  clr        in   1      reset, synchronous, active-high
//  id_rs      in   REG_W  source reg 1 of instruction in ID
//  id_rt      in   REG_W  source reg 2 of instruction in ID
//  id_use_rs  in   1      ID instruction reads id_rs
//  id_use_rt  in   1      ID instruction reads id_rt
//  ex_rd      in   REG_W  dest reg of instruction in EX
//  ex_regwr   in   1      EX instruction writes register file
//  ex_dmld    in   1      EX instruction is a load
//  mem_rd     in   REG_W  dest reg in MEM;  mem_regwr in 1  MEM writes RF
//  wb_rd      in   REG_W  dest reg in WB;   wb_regwr  in 1  WB writes RF
//  br_taken   in   1      branch/jump resolved taken in EX
//  mem_busy   in   1      data memory not ready; pipeline must freeze
//  pc_en      out  1      PC load enable
//  ifid_en    out  1      IF/ID enable;  ifid_clr out 1  IF/ID sync clear
//  idex_en    out  1      ID/EX enable;  idex_clr out 1  ID/EX sync clear (bubble)
//  rfd1sel    out  2      fwd select rs: 00 RF, 01 MEM result, 10 WB result
//  rfd2sel    out  2      fwd select rt: same encoding
//  wait_err   out  1      sticky: mem_busy exceeded MAX_WAIT consecutive cycles
//  stall_cnt  out  CNT_W  stall-cycle count (only with HAZ_PERF_CNT_EN)
// BEHAVIOUR
//  Reset (clr=1 at edge): state=RUN, wait counter=0, wait_err=0, stall_cnt=0.
//   While clr=1 outputs are: pc_en=0, ifid_en=idex_en=1, ifid_clr=idex_clr=1, selects 00.
//  Register 0 never matches (rd==0 ignored for every hazard/forward compare).
//  Hazard conditions evaluated combinationally each cycle; priority MEMWAIT > FLUSH > LOADUSE.
//  - mem_busy=1: freeze: pc_en=ifid_en=idex_en=0, no clears. State MEMWAIT; wait counter
//    increments (saturates); reaching MAX_WAIT+1 sets wait_err (cleared only by clr).
//    mem_busy=0 -> state RUN, counter=0, normal evaluation same cycle.
//  - br_taken (no mem_busy): pc_en=1, ifid_clr=1, idex_clr=1 for exactly one cycle.
//    A simultaneous load-use hazard is discarded (younger instr is squashed).
//  - load-use: ex_dmld & ex_regwr & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) |
//    (id_use_rt & id_rt==ex_rd)): pc_en=0, ifid_en=0, idex_clr=1 (one bubble). State
//    LDSTALL for one cycle; in LDSTALL the same load cannot re-trigger (it is now in MEM),
//    return to RUN next edge. Exactly 1 stall cycle per load-use hazard.
//  - none: pc_en=ifid_en=idex_en=1, clears 0.
//  Forwarding (independent of FSM, zero latency): rfd1sel=01 if mem_regwr & mem_rd==id_rs
//   & id_rs!=0; else 10 if wb_regwr & wb_rd==id_rs & id_rs!=0; else 00. MEM wins over WB.
//   rfd2sel identical on id_rt. 11 never produced.
//  States: RUN, LDSTALL, MEMWAIT. Encoding free; all illegal states recover to RUN.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: stall_cnt increments (saturating at all-ones) every cycle with
//   pc_en=0 and clr=0. Undefined: stall_cnt tied to 0, no counter flops.
// TESTING
//  1 clr=1 two cycles -> pc_en=0, both clears 1, wait_err=0; clr=0 idle -> all enables 1.
//  2 EX lw rd=5, ID add rs=5 -> one cycle pc_en=0, ifid_en=0, idex_clr=1; next cycle
//    rfd1sel=01 (rd=5 now in MEM); rd=0 load -> no stall.
//  3 br_taken=1 with concurrent load-use -> ifid_clr=idex_clr=1, pc_en=1, no LDSTALL.
//  4 mem_busy high 16 cycles with MAX_WAIT=15 -> all enables 0 throughout, wait_err=1 from
//    cycle 16, stays 1 after mem_busy drops until clr.
//  5 mem_rd=wb_rd=7 both writing, id_rs=id_rt=7 -> rfd1sel=rfd2sel=01; mem_regwr=0 -> 10.
//  6 HAZ_PERF_CNT_EN: two load-use stalls + 3 busy cycles -> stall_cnt=5.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles the hazard controller's pipeline-side inputs and control outputs.
//   Inputs to the controller: id_rs/id_rt/id_use_rs/id_use_rt (decode operands), ex_rd/ex_regwr/
//   ex_dmld (EX writer), mem_rd/mem_regwr, wb_rd/wb_regwr (later writers), br_taken, mem_busy.
//   Outputs from the controller: pc_en, ifid_en/ifid_clr, idex_en/idex_clr, rfd1sel/rfd2sel,
//   wait_err, stall_cnt.
//   master: pipeline side that drives the hazard inputs; slave: the controller itself.
interface hazard_ctrl_if #(parameter int REG_W = 5, parameter int CNT_W = 16);
   logic [REG_W-1:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
   logic             id_use_rs, id_use_rt, ex_regwr, ex_dmld, mem_regwr, wb_regwr;
   logic             br_taken, mem_busy;
   logic             pc_en, ifid_en, ifid_clr, idex_en, idex_clr, wait_err;
   logic [1:0]       rfd1sel, rfd2sel;
   logic [CNT_W-1:0] stall_cnt;
   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_regwr, ex_dmld,
             mem_rd, mem_regwr, wb_rd, wb_regwr, br_taken, mem_busy,
      input  pc_en, ifid_en, ifid_clr, idex_en, idex_clr, rfd1sel, rfd2sel, wait_err, stall_cnt
   );
   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_regwr, ex_dmld,
             mem_rd, mem_regwr, wb_rd, wb_regwr, br_taken, mem_busy,
      output pc_en, ifid_en, ifid_clr, idex_en, idex_clr, rfd1sel, rfd2sel, wait_err, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/bubble/flush sequencer and operand forwarding select generator.
//   clk : clock, rising edge
//   clr : synchronous active-high reset
//   hz  : hazard_ctrl_if.slave (decode/EX/MEM/WB hazard inputs, PC and stage-register controls,
//         forwarding selects, sticky wait_err, stall_cnt)
//   Optional macro HAZ_PERF_CNT_EN: enables the saturating stall-cycle counter on stall_cnt;
//   without it stall_cnt is tied to zero and no counter flops exist.
module hazard_ctrl #(
   parameter int REG_W    = 5,
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input logic          clk,
   input logic          clr,
   hazard_ctrl_if.slave hz
);
   localparam int               WC_W   = $clog2(MAX_WAIT + 2);
   localparam logic [WC_W-1:0]  WC_MAX = WC_W'(MAX_WAIT + 1);
   localparam logic [REG_W-1:0] R0     = '0;
   typedef enum logic [1:0] {RUN = 2'd0, LDSTALL = 2'd1, MEMWAIT = 2'd2} state_t;
   state_t          r_state, w_next;
   logic [WC_W-1:0] r_wcnt;
   logic            r_wait_err;
   logic            w_lu, w_pc_en, w_ifid_en, w_ifid_clr, w_idex_en, w_idex_clr;
   // In LDSTALL the load that caused the bubble has moved to MEM, so it must not stall again.
   assign w_lu = hz.ex_dmld & hz.ex_regwr & (hz.ex_rd != R0) & (r_state != LDSTALL) &
                 ((hz.id_use_rs & (hz.id_rs == hz.ex_rd)) | (hz.id_use_rt & (hz.id_rt == hz.ex_rd)));
   always_ff @(posedge clk) begin
      if (clr) r_state <= RUN;
      else     r_state <= w_next;
   end
   // A taken branch squashes the ID instruction, so its load-use hazard never stalls.
   always_comb begin
      w_next = hz.mem_busy ? MEMWAIT : (!hz.br_taken && w_lu) ? LDSTALL : RUN;
   end
   always_comb begin
      w_pc_en    = 1'b1;
      w_ifid_en  = 1'b1;
      w_idex_en  = 1'b1;
      w_ifid_clr = 1'b0;
      w_idex_clr = 1'b0;
      if (clr) begin
         w_pc_en    = 1'b0;
         w_ifid_clr = 1'b1;
         w_idex_clr = 1'b1;
      end else if (hz.mem_busy) begin
         w_pc_en   = 1'b0;
         w_ifid_en = 1'b0;
         w_idex_en = 1'b0;
      end else if (hz.br_taken) begin
         w_ifid_clr = 1'b1;
         w_idex_clr = 1'b1;
      end else if (w_lu) begin
         w_pc_en    = 1'b0;
         w_ifid_en  = 1'b0;
         w_idex_clr = 1'b1;
      end
   end
   // Wait counter saturates at MAX_WAIT+1; the flag latches on the edge that reaches it.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_wcnt     <= '0;
         r_wait_err <= 1'b0;
      end else if (hz.mem_busy) begin
         if (r_wcnt != WC_MAX) r_wcnt <= r_wcnt + 1'b1;
         r_wait_err <= r_wait_err | (r_wcnt >= WC_MAX - 1'b1);
      end else begin
         r_wcnt <= '0;
      end
   end
   assign hz.pc_en    = w_pc_en;
   assign hz.ifid_en  = w_ifid_en;
   assign hz.ifid_clr = w_ifid_clr;
   assign hz.idex_en  = w_idex_en;
   assign hz.idex_clr = w_idex_clr;
   assign hz.wait_err = r_wait_err;
   // MEM result is younger than WB, so it wins when both match.
   assign hz.rfd1sel = (clr || hz.id_rs == R0) ? 2'b00 :
                       (hz.mem_regwr && hz.mem_rd == hz.id_rs) ? 2'b01 :
                       (hz.wb_regwr && hz.wb_rd == hz.id_rs) ? 2'b10 : 2'b00;
   assign hz.rfd2sel = (clr || hz.id_rt == R0) ? 2'b00 :
                       (hz.mem_regwr && hz.mem_rd == hz.id_rt) ? 2'b01 :
                       (hz.wb_regwr && hz.wb_rd == hz.id_rt) ? 2'b10 : 2'b00;
`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   always_ff @(posedge clk) begin
      if (clr)                         r_stall_cnt <= '0;
      else if (!w_pc_en && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
   end
   assign hz.stall_cnt = r_stall_cnt;
`else
   assign hz.stall_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;
`ifdef HAZ_PERF_CNT_EN
   localparam int EXP_SC = 5;
`else
   localparam int EXP_SC = 0;
`endif
   logic clk = 1'b0;
   logic clr = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) hz ();
   hazard_ctrl #(.REG_W(5), .MAX_WAIT(15), .CNT_W(16)) dut (.clk(clk), .clr(clr), .hz(hz));
   always #5 clk = ~clk;
   // {pc_en, ifid_en, ifid_clr, idex_en, idex_clr}
   function automatic logic [31:0] ctl();
      return {27'd0, hz.pc_en, hz.ifid_en, hz.ifid_clr, hz.idex_en, hz.idex_clr};
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      hz.id_rs = '0; hz.id_rt = '0; hz.id_use_rs = 0; hz.id_use_rt = 0;
      hz.ex_rd = '0; hz.ex_regwr = 0; hz.ex_dmld = 0;
      hz.mem_rd = '0; hz.mem_regwr = 0; hz.wb_rd = '0; hz.wb_regwr = 0;
      hz.br_taken = 0; hz.mem_busy = 0;
   endtask
   task automatic load_use(input logic [4:0] r);
      hz.ex_dmld = 1; hz.ex_regwr = 1; hz.ex_rd = r; hz.id_rs = r; hz.id_use_rs = 1;
   endtask
   initial begin
      idle();
      hz.mem_rd = 5'd3; hz.mem_regwr = 1; hz.id_rs = 5'd3;
      tick(); tick();
      #2;
      chk("reset_ctl", ctl(), 'b01111);
      chk("reset_wait_err", 32'(hz.wait_err), 0);
      chk("reset_fwd_forced_rf", 32'(hz.rfd1sel), 0);
      clr = 0;
      #1;
      chk("idle_ctl", ctl(), 'b11010);
      chk("idle_fwd_mem", 32'(hz.rfd1sel), 1);
      tick();
      // load-use on rs: one bubble, then forward from MEM
      idle(); load_use(5'd5);
      #2 chk("lu_rs_stall", ctl(), 'b00011);
      tick();
      hz.mem_rd = 5'd5; hz.mem_regwr = 1;
      #2 chk("lu_no_retrigger", ctl(), 'b11010);
      chk("lu_fwd_mem", 32'(hz.rfd1sel), 1);
      tick();
      idle(); load_use(5'd0);
      #2 chk("lu_rd0_no_stall", ctl(), 'b11010);
      tick();
      idle(); hz.ex_dmld = 1; hz.ex_regwr = 1; hz.ex_rd = 5'd9; hz.id_rt = 5'd9; hz.id_use_rt = 1;
      #2 chk("lu_rt_stall", ctl(), 'b00011);
      tick();
      idle(); tick();
      hz.ex_dmld = 1; hz.ex_regwr = 1; hz.ex_rd = 5'd9; hz.id_rt = 5'd9;
      #2 chk("lu_rt_unused", ctl(), 'b11010);
      hz.ex_dmld = 0;
      #1 chk("nonload_no_stall", ctl(), 'b11010);
      tick();
      // branch taken squashes a simultaneous load-use
      idle(); load_use(5'd6); hz.br_taken = 1;
      #2 chk("br_flush", ctl(), 'b11111);
      tick();
      hz.br_taken = 0;
      #2 chk("br_then_run_lu", ctl(), 'b00011);
      tick();
      // memory wait: priority over flush, boundary at MAX_WAIT
      idle(); hz.mem_busy = 1; hz.br_taken = 1; load_use(5'd4);
      #2 chk("busy_over_br", ctl(), 'b00000);
      for (int i = 0; i < 14; i++) tick();
      idle(); hz.mem_busy = 1;
      tick();
      hz.mem_busy = 0;
      #2 chk("wait15_no_err", 32'(hz.wait_err), 0);
      chk("busy_drop_run", ctl(), 'b11010);
      tick();
      hz.mem_busy = 1;
      for (int i = 0; i < 16; i++) begin
         #2 chk($sformatf("busy16_ctl_%0d", i), ctl(), 'b00000);
         chk($sformatf("busy16_err_%0d", i), 32'(hz.wait_err), 0);
         tick();
      end
      hz.mem_busy = 0;
      #2 chk("wait16_err", 32'(hz.wait_err), 1);
      tick(); tick();
      chk("wait_err_sticky", 32'(hz.wait_err), 1);
      clr = 1; tick(); clr = 0;
      #2 chk("wait_err_cleared", 32'(hz.wait_err), 0);
      // forwarding selects
      idle(); hz.mem_rd = 5'd7; hz.wb_rd = 5'd7; hz.mem_regwr = 1; hz.wb_regwr = 1;
      hz.id_rs = 5'd7; hz.id_rt = 5'd7;
      #2 chk("fwd1_mem_wins", 32'(hz.rfd1sel), 1);
      chk("fwd2_mem_wins", 32'(hz.rfd2sel), 1);
      hz.mem_regwr = 0;
      #1 chk("fwd1_wb", 32'(hz.rfd1sel), 2);
      chk("fwd2_wb", 32'(hz.rfd2sel), 2);
      hz.id_rt = 5'd8;
      #1 chk("fwd2_nomatch", 32'(hz.rfd2sel), 0);
      hz.wb_regwr = 0;
      #1 chk("fwd1_rf", 32'(hz.rfd1sel), 0);
      hz.id_rs = 5'd0; hz.mem_rd = 5'd0; hz.mem_regwr = 1;
      #1 chk("fwd_r0", 32'(hz.rfd1sel), 0);
      tick();
      // stall counter: two load-use stalls plus three busy cycles
      clr = 1; tick(); clr = 0;
      idle(); load_use(5'd2); tick();
      idle(); tick();
      load_use(5'd3); tick();
      idle(); tick();
      hz.mem_busy = 1; tick(); tick(); tick();
      hz.mem_busy = 0;
      #2 chk("stall_cnt", 32'(hz.stall_cnt), EXP_SC);
      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
